// File: rtl/serial_subtractor_pkg.sv
// Package: serial_subtractor_pkg
// Purpose: shared definitions for the bit-serial subtractor.
//   - state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2), also used by the
//               debug state output so checkers can follow the sequencer.
//   - MIN_WIDTH : smallest legal operand width. The counter is $clog2(WIDTH)
//                 bits wide and needs at least one bit.
//   - width_ok() : helper for a static legality check of WIDTH.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Interface: serial_subtractor_if
// Purpose: operand and result handshakes of the serial subtractor.
//
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its data
// stable until that edge; ready may rise or fall freely and never depends
// combinationally on valid.
//
// Signals:
//   in_valid  / in_ready  : operand handshake (a_in, b_in, bor_in)
//   out_valid / out_ready : result handshake (diff_out, bor_out)
// Modports:
//   master : operand producer / result consumer (testbench or upstream logic)
//   slave  : the subtractor itself
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bor_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff_out;
    logic             bor_out;

    modport master (
        output in_valid, a_in, b_in, bor_in, out_ready,
        input  in_ready, out_valid, diff_out, bor_out
    );

    modport slave (
        input  in_valid, a_in, b_in, bor_in, out_ready,
        output in_ready, out_valid, diff_out, bor_out
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Module: full_subtractor
// Purpose: 1-bit combinational full subtractor, diff = a - b - borrow.
// Ports:
//   a_in     : minuend bit
//   b_in     : subtrahend bit
//   bor_in   : borrow in
//   diff_out : difference bit
//   bor_out  : borrow out, set when a_in < b_in + bor_in
module full_subtractor (
    input  logic a_in,
    input  logic b_in,
    input  logic bor_in,
    output logic diff_out,
    output logic bor_out
);
    assign diff_out = a_in ^ b_in ^ bor_in;
    // Borrow when b is set and a is clear, or when a == b and a borrow arrives.
    assign bor_out  = (~a_in & b_in) | (~(a_in ^ b_in) & bor_in);
endmodule

// File: rtl/serial_subtractor.sv
// Module: serial_subtractor
// Purpose: bit-serial subtractor, diff = a - b - bor, LSB first, one bit per
//   clock through a single full_subtractor cell. WIDTH must be >= 2.
// Ports:
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : slave side of serial_subtractor_if (operand and result
//                 handshakes, see the interface for the handshake rule)
//   dbg_state_o : current FSM state, for debug and checkers
// Timing: operands accepted at edge k give out_valid after edge k+WIDTH.
//   The result is held in DONE until out_ready; in_ready is high only in IDLE.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_subtractor_if.slave   bus,
    output state_t               dbg_state_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Holds the WIDTH-1 difference bits produced so far; the last bit comes
    // straight from the cell when the result is loaded.
    logic [WIDTH-2:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             fs_diff;
    logic             fs_bor;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_fs (
        .a_in     (a_q[0]),
        .b_in     (b_q[0]),
        .bor_in   (brw_q),
        .diff_out (fs_diff),
        .bor_out  (fs_bor)
    );

    // New difference bit enters at the MSB; after WIDTH steps the first
    // (LSB) bit has reached bit 0.
    assign res_shift = {fs_diff, res_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    brw_d   = bus.bor_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift[WIDTH-1:1];
                brw_d = fs_bor;
                if (cnt_q == LAST_BIT) begin
                    // Counter is left at WIDTH-1 so it never wraps.
                    diff_d  = res_shift;
                    bout_d  = fs_bor;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.diff_out  = diff_q;
    assign bus.bor_out   = bout_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        reset_n = 1'b0;
        #100 reset_n = 1'b1;
    end

    // ---------------- DUTs ----------------
    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(2)) if2 ();
    state_t dbg8;
    state_t dbg2;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (if8.slave),
        .dbg_state_o (dbg8)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (if2.slave),
        .dbg_state_o (dbg2)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q8[$];
    logic [2:0] exp_q2[$];
    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;  // 0: out_ready=1, 1: random, 2: driven by main sequence

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // out_ready driver for the 8-bit DUT
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) if8.out_ready = 1'b1;
            else if (rdy_mode == 1) if8.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // monitors: a transfer seen at a negedge completes on the next posedge
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && if8.out_valid && if8.out_ready) begin
                if (exp_q8.size() == 0) begin
                    chk("unexpected_out8", {23'd0, if8.bor_out, if8.diff_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q8.pop_front();
                    chk("result8", {23'd0, if8.bor_out, if8.diff_out}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && if2.out_valid && if2.out_ready) begin
                if (exp_q2.size() == 0) begin
                    chk("unexpected_out2", {29'd0, if2.bor_out, if2.diff_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q2.pop_front();
                    chk("result2", {29'd0, if2.bor_out, if2.diff_out}, {29'd0, e});
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input bit push, input logic [8:0] exp);
        int guard = 0;
        if8.a_in = a;
        if8.b_in = b;
        if8.bor_in = bi;
        if8.in_valid = 1'b1;
        @(negedge clk);
        while (!if8.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!if8.in_ready) begin
            fail_now("accept8");
            @(posedge clk);
            #1;
            if8.in_valid = 1'b0;
            return;
        end
        if (push) exp_q8.push_back(exp);
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bi,
                       input logic [2:0] exp);
        int guard = 0;
        if2.a_in = a;
        if2.b_in = b;
        if2.bor_in = bi;
        if2.in_valid = 1'b1;
        @(negedge clk);
        while (!if2.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!if2.in_ready) begin
            fail_now("accept2");
        end else begin
            exp_q2.push_back(exp);
        end
        @(posedge clk);
        #1;
        if2.in_valid = 1'b0;
    endtask

    task automatic drain8();
        int guard = 0;
        while ((exp_q8.size() != 0 || dbg8 != ST_IDLE) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q8.size() != 0 || dbg8 != ST_IDLE) fail_now("drain8");
        @(posedge clk);
        #1;
    endtask

    task automatic drain2();
        int guard = 0;
        while ((exp_q2.size() != 0 || dbg2 != ST_IDLE) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q2.size() != 0 || dbg2 != ST_IDLE) fail_now("drain2");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle8(input string nm);
        chk({nm, "_in_ready"},  {31'd0, if8.in_ready},  32'd1);
        chk({nm, "_out_valid"}, {31'd0, if8.out_valid}, 32'd0);
        chk({nm, "_diff"},      {24'd0, if8.diff_out},  32'h00);
        chk({nm, "_bor"},       {31'd0, if8.bor_out},   32'd0);
        chk({nm, "_state"},     {30'd0, dbg8},          {30'd0, ST_IDLE});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [7:0] ra, rb;
        logic       rbi;
        if8.in_valid = 1'b0; if8.a_in = '0; if8.b_in = '0; if8.bor_in = 1'b0; if8.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.a_in = '0; if2.b_in = '0; if2.bor_in = 1'b0; if2.out_ready = 1'b1;

        // 1. reset values, clock running
        @(negedge clk);
        @(negedge clk);
        chk_idle8("in_reset");
        @(posedge reset_n);
        @(negedge clk);
        chk_idle8("after_reset");
        @(posedge clk);
        #1;

        // 2. basic subtraction and latency
        op8(8'h05, 8'h03, 1'b0, 1, 9'h002);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!if8.out_valid && n < 20);
        chk("latency", n, 8);
        drain8();

        // 3. borrow cases
        op8(8'h03, 8'h05, 1'b0, 1, 9'h1FE);
        op8(8'h00, 8'h00, 1'b1, 1, 9'h1FF);
        op8(8'hFF, 8'hFF, 1'b1, 1, 9'h1FF);
        drain8();

        // 4. result held while out_ready is low; in_valid ignored
        rdy_mode = 2;
        if8.out_ready = 1'b0;
        op8(8'h5A, 8'h21, 1'b0, 1, 9'h039);
        n = 0;
        while (!if8.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reach_done", {31'd0, if8.out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if8.in_valid = 1'($urandom_range(0, 1));
            if8.a_in     = 8'($urandom_range(0, 255));
            if8.b_in     = 8'($urandom_range(0, 255));
            if8.bor_in   = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_valid", {31'd0, if8.out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, if8.in_ready}, 32'd0);
            chk("hold_result", {23'd0, if8.bor_out, if8.diff_out}, 32'h039);
            chk("hold_state", {30'd0, dbg8}, {30'd0, ST_DONE});
        end
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_state", {30'd0, dbg8}, {30'd0, ST_IDLE});
        chk("release_valid", {31'd0, if8.out_valid}, 32'd0);
        @(negedge clk);
        chk("no_capture", {30'd0, dbg8}, {30'd0, ST_IDLE});
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // 5. reset mid-RUN
        op8(8'h11, 8'h22, 1'b0, 0, 9'h000);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_in_run", {30'd0, dbg8}, {30'd0, ST_RUN});
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, if8.out_valid}, 32'd0);
        chk("abort_state", {30'd0, dbg8}, {30'd0, ST_IDLE});
        chk("abort_in_ready", {31'd0, if8.in_ready}, 32'd1);
        chk("abort_result", {23'd0, if8.bor_out, if8.diff_out}, 32'h000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        op8(8'h80, 8'h01, 1'b0, 1, 9'h07F);
        drain8();

        // 6a. random run against the arithmetic model
        rdy_mode = 1;
        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            op8(ra, rb, rbi, 1, {1'b0, ra} - {1'b0, rb} - {8'd0, rbi});
        end
        drain8();
        rdy_mode = 0;

        // 6b. exhaustive sweep at WIDTH=2
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    op2(2'(a), 2'(b), 1'(c), 3'(a) - 3'(b) - 3'(c));
                end
            end
        end
        drain2();

        chk("q8_empty", exp_q8.size(), 0);
        chk("q2_empty", exp_q2.size(), 0);
        chk("end_state2", {30'd0, dbg2}, {30'd0, ST_IDLE});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
